el2_trace_buf: RTL

//  Parametrised retirement-trace buffer and serializer. Captures one el2 trace record per retired

---
 rtl/el2_trace_buf.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/el2_trace_buf.sv
// el2_trace_buf: retirement-trace record FIFO, beat serializer and saturating drop counter.
// Optional build macro EL2_TRACE_LOSS_FLAG_EN: record bit 103 marks records lost before this one.
module el2_trace_buf #(
    parameter int DEPTH = 8,
    parameter int OUT_W = 32,
    parameter int OVF_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_l,
    input  logic                       trace_en,
    input  logic                       trace_rv_i_valid_ip,
    input  logic [31:0]                trace_rv_i_insn_ip,
    input  logic [31:0]                trace_rv_i_address_ip,
    input  logic                       trace_rv_i_exception_ip,
    input  logic [4:0]                 trace_rv_i_ecause_ip,
    input  logic                       trace_rv_i_interrupt_ip,
    input  logic [31:0]                trace_rv_i_tval_ip,
    output logic                       trc_out_valid,
    output logic [OUT_W-1:0]           trc_out_data,
    output logic                       trc_out_last,
    input  logic                       trc_out_ready,
    output logic [$clog2(DEPTH+1)-1:0] trc_level,
    output logic [OVF_W-1:0]           trc_ovf_cnt,
    input  logic                       trc_ovf_clr
);
    localparam int REC_W  = 104;
    localparam int BEATS  = (REC_W + OUT_W - 1) / OUT_W;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = $clog2(DEPTH + 1);
    localparam int BIDX_W = $clog2(BEATS);
    localparam logic [BIDX_W-1:0] LAST_BIDX = BIDX_W'(BEATS - 1);
    localparam logic [LVL_W-1:0]  FULL_LVL  = LVL_W'(DEPTH);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                 state_reg, state_next;
    logic [BIDX_W-1:0]      bidx_reg, bidx_next;
    logic [PTR_W-1:0]       wr_ptr_reg, rd_ptr_reg;
    logic [LVL_W-1:0]       level_reg, level_next;
    logic [OVF_W-1:0]       ovf_cnt_reg;
    logic [REC_W-1:0]       mem [DEPTH];
    logic [REC_W-1:0]       push_rec;
    logic [BEATS*OUT_W-1:0] head_pad;
    logic [OUT_W-1:0]       beat_arr [BEATS];
    logic                   push_req, push, pop, drop, space, flag;

    assign push_req = trace_en & trace_rv_i_valid_ip;
    assign pop      = (state_reg == SEND) & trc_out_ready & (bidx_reg == LAST_BIDX);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign space    = (level_reg != FULL_LVL) | pop;
    assign push     = push_req & space;
    assign drop     = push_req & ~space;

`ifdef EL2_TRACE_LOSS_FLAG_EN
    logic loss_pend_reg;
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l)    loss_pend_reg <= 1'b0;
        else if (drop) loss_pend_reg <= 1'b1;
        else if (push) loss_pend_reg <= 1'b0;
    end
    assign flag = loss_pend_reg;
`else
    assign flag = 1'b0;
`endif

    assign push_rec = {flag, trace_rv_i_tval_ip, trace_rv_i_interrupt_ip, trace_rv_i_ecause_ip,
                       trace_rv_i_exception_ip, trace_rv_i_address_ip, trace_rv_i_insn_ip};

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= push_rec;
    end

    always_comb begin
        head_pad            = '0;
        head_pad[REC_W-1:0] = mem[rd_ptr_reg];
    end

    for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
        assign beat_arr[gi] = head_pad[gi*OUT_W +: OUT_W];
    end

    always_comb begin
        level_next = level_reg;
        if (push && !pop)      level_next = level_reg + 1'b1;
        else if (pop && !push) level_next = level_reg - 1'b1;
    end

    // Next state looks at level_next so a push into an empty FIFO is presented next cycle.
    always_comb begin
        state_next    = state_reg;
        bidx_next     = bidx_reg;
        trc_out_valid = 1'b0;
        trc_out_last  = 1'b0;
        trc_out_data  = '0;
        case (state_reg)
            IDLE: begin
                if (level_next != '0) begin
                    state_next = SEND;
                    bidx_next  = '0;
                end
            end
            SEND: begin
                trc_out_valid = 1'b1;
                trc_out_last  = (bidx_reg == LAST_BIDX);
                trc_out_data  = beat_arr[bidx_reg];
                if (trc_out_ready) begin
                    if (bidx_reg == LAST_BIDX) begin
                        bidx_next = '0;
                        if (level_next == '0) state_next = IDLE;
                    end else begin
                        bidx_next = bidx_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_reg  <= IDLE;
            bidx_reg   <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            state_reg <= state_next;
            bidx_reg  <= bidx_next;
            level_reg <= level_next;
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            ovf_cnt_reg <= '0;
        end else if (trc_ovf_clr) begin
            ovf_cnt_reg <= drop ? OVF_W'(1) : '0;
        end else if (drop && (ovf_cnt_reg != '1)) begin
            ovf_cnt_reg <= ovf_cnt_reg + 1'b1;
        end
    end

    assign trc_level   = level_reg;
    assign trc_ovf_cnt = ovf_cnt_reg;
endmodule
